// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU front end: data width, fetch FSM
// states, next-PC source encodings and the default reset PC.
package cpu_pkg;

  localparam int WORD_WIDTH = 16;
  localparam logic [WORD_WIDTH-1:0] RESET_PC_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } fetch_state_e;

  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_REG    = 2'd3;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection; shared with the branch-resolution logic.
module next_pc_calc
  import cpu_pkg::*;
#(
  parameter int W = WORD_WIDTH
) (
  input  logic [W-1:0] pc_i,
  input  logic [1:0]   pc_sel_i,
  input  logic [7:0]   branch_offset_i,
  input  logic [11:0]  jump_target_i,
  input  logic [W-1:0] reg_target_i,
  output logic [W-1:0] next_pc_o
);

  logic [W-1:0] seq_pc;
  logic [W-1:0] offset_ext;

  assign seq_pc     = pc_i + W'(1);
  assign offset_ext = {{(W-8){branch_offset_i[7]}}, branch_offset_i};

  always_comb begin
    next_pc_o = seq_pc;
    case (pc_sel_i)
      PC_SEQ:    next_pc_o = seq_pc;
      PC_BRANCH: next_pc_o = seq_pc + offset_ext;
      PC_JUMP:   next_pc_o = {pc_i[W-1:12], jump_target_i};
      PC_REG:    next_pc_o = reg_target_i;
      default:   next_pc_o = seq_pc;
    endcase
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// PC register, instruction-memory read handshake and instruction register.
// Build option FETCH_TIMEOUT_EN adds a wait counter and sticky fetch_error output.
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter int WORD_WIDTH = cpu_pkg::WORD_WIDTH,
  parameter logic [WORD_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 15
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic                  pc_write,
  input  logic [1:0]            pc_sel,
  input  logic [7:0]            branch_offset,
  input  logic [11:0]           jump_target,
  input  logic [WORD_WIDTH-1:0] reg_target,
  output logic                  i_readM,
  output logic [WORD_WIDTH-1:0] i_address,
  input  logic [WORD_WIDTH-1:0] i_data,
  input  logic                  inputReady,
  output logic [WORD_WIDTH-1:0] instruction,
  output logic                  IRWrite,
  output logic [WORD_WIDTH-1:0] pc,
`ifdef FETCH_TIMEOUT_EN
  output logic                  fetch_error,
`endif
  output logic                  fetch_busy
);

  fetch_state_e          state_q;
  logic [WORD_WIDTH-1:0] pc_q;
  logic [WORD_WIDTH-1:0] pc_d;
  logic [WORD_WIDTH-1:0] instr_q;

`ifdef FETCH_TIMEOUT_EN
  logic [3:0] wait_cnt_q;
  logic       fetch_error_q;
`endif

  next_pc_calc #(.W(WORD_WIDTH)) u_next_pc (
    .pc_i            (pc_q),
    .pc_sel_i        (pc_sel),
    .branch_offset_i (branch_offset),
    .jump_target_i   (jump_target),
    .reg_target_i    (reg_target),
    .next_pc_o       (pc_d)
  );

  // pc_q only moves outside REQ, so the address stays stable for the whole request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt_q    <= '0;
      fetch_error_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (pc_write) pc_q <= pc_d;
          state_q <= fetch_req ? REQ : IDLE;
`ifdef FETCH_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
        end
        REQ: begin
          if (inputReady) begin
            instr_q <= i_data;
            state_q <= DONE;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (wait_cnt_q == 4'(TIMEOUT_CYCLES - 1)) begin
            fetch_error_q <= 1'b1;
            state_q       <= IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 4'd1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign i_readM     = (state_q == REQ);
  assign fetch_busy  = (state_q == REQ);
  assign i_address   = (state_q == REQ) ? pc_q : '0;
  assign IRWrite     = (state_q == DONE);
  assign instruction = instr_q;
  assign pc          = pc_q;
`ifdef FETCH_TIMEOUT_EN
  assign fetch_error = fetch_error_q;
`endif

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Front end of the Lab5 multicycle CPU, directly upstream of the instruction decoder.
- Holds the program counter and runs a read request/ready handshake with instruction memory.
- Latches the returned 16-bit word into the instruction register and pulses IRWrite so the decoder captures the fields.
- Computes the next PC (sequential, branch, jump, register) on command from the control unit.

Parameters:
- WORD_WIDTH, 16, instruction, PC and memory data/address width
- RESET_PC, 16'h0000, PC value loaded on reset
- TIMEOUT_CYCLES, 15, wait cycles before fetch_error (only with the optional feature)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- fetch_req  input  1  control requests fetch of the instruction at the current pc
- pc_write  input  1  control commits the next PC this cycle
- pc_sel  input  2  next-PC source: 0 = PC+1, 1 = branch, 2 = jump, 3 = register
- branch_offset  input  8  signed branch offset (decoder immediate)
- jump_target  input  12  jump target field (decoder target address)
- reg_target  input  16  register value for jump-register
- i_readM  output  1  memory read request
- i_address  output  16  memory address
- i_data  input  16  memory read data
- inputReady  input  1  memory data valid this cycle
- instruction  output  16  instruction register contents
- IRWrite  output  1  one-cycle pulse: instruction register just loaded
- pc  output  16  current program counter
- fetch_busy  output  1  high in REQ state

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - state = IDLE, pc = RESET_PC, instruction = 0
  - IRWrite = 0, i_readM = 0, i_address = 0, fetch_busy = 0
  - Reset during REQ drops i_readM without waiting for a clock edge.
- FSM states: IDLE, REQ, DONE.
  - IDLE: i_readM = 0. fetch_req → REQ on the next edge.
  - REQ: i_readM = 1, i_address = pc, fetch_busy = 1. Stays in REQ until inputReady = 1. On that edge: instruction ← i_data, state → DONE.
  - DONE: IRWrite = 1 for exactly this cycle. Then fetch_req → REQ, otherwise → IDLE.
- Latency:
  - fetch_req is sampled at edge N, so REQ begins at edge N.
  - If inputReady is already high in that first REQ cycle, IRWrite is high in the cycle after edge N+1.
  - Minimum is 2 cycles from fetch_req to IRWrite. Each additional wait cycle adds one.
- inputReady outside REQ is ignored. The instruction register changes only on the REQ→DONE edge.
- PC update:
  - pc_write is honoured in IDLE and DONE only; in REQ it is ignored (pc holds).
  - Next-PC sources:
    - sel 0: pc + 1
    - sel 1: pc + 1 + sign_extend(branch_offset)
    - sel 2: {pc[15:12], jump_target}
    - sel 3: reg_target
  - All arithmetic is modulo 2^16; 16'hFFFF + 1 wraps to 0.
- pc_write and fetch_req in the same IDLE/DONE cycle: the PC updates on that edge and REQ drives the new pc.
- fetch_req while in REQ: ignored; there is no queuing.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN
- Defined:
  - Adds output fetch_error (1 bit) and a 4-bit wait counter.
  - The counter clears on entry to REQ and increments each REQ cycle without inputReady.
  - When it reaches TIMEOUT_CYCLES: fetch_error is set (sticky until reset), state → IDLE, i_readM drops, instruction is unchanged and no IRWrite is issued.
- Undefined: no port and no counter; REQ waits indefinitely.

Decomposition:
- Shared package (cpu_pkg):
  - WORD_WIDTH
  - fetch state enum (IDLE/REQ/DONE)
  - pc_sel encoding constants: PC_SEQ, PC_BRANCH, PC_JUMP, PC_REG
  - RESET_PC default
- One sub-module, next_pc_calc: purely combinational next-PC mux and adders. It is reused later by the branch-resolution logic.

Test Plan:
- Reset, then fetch_req pulse with memory inputReady same cycle, i_data = 16'h6A41 → IRWrite high 2 cycles after fetch_req; instruction = 16'h6A41; i_address = 0.
- Memory inserts 3 wait cycles → i_readM held high 4 cycles with stable i_address; IRWrite exactly once; fetch_busy high throughout.
- pc = 16'h0010, pc_write with sel 1, offset 8'hFE → pc = 16'h000F. Then sel 2, target 12'h123 with pc = 16'hA00F → pc = 16'hA123.
- pc = 16'hFFFF, sel 0 → pc = 16'h0000. pc_write asserted during REQ → pc unchanged.
- Assert reset during REQ wait → i_readM low immediately, pc = RESET_PC. A later inputReady produces no IRWrite.
- With FETCH_TIMEOUT_EN, memory never ready → fetch_error rises after 15 REQ cycles, state IDLE, no IRWrite; the next reset clears it.
